axi_dma_r_burst_gen: RTL

Burst generator placed directly upstream of the AXI DMA read engine. It accepts one read descriptor: a start address and a total transfer length in bus beats. It splits the transfer into AXI INCR bursts, bounded by a maximum burst size and, optionally, the 4 KB AXI boundary, and drives the engine's `valid/addr/len` request port. It counts the engine's per-beat `ready` strobes, forwards read data to the consumer with a transfer-level `last` flag, and pulses `done` when the transfer completes.

---
 rtl/axi_dma_r_burst_gen_pkg.sv | 22 ++
 rtl/axi_dma_r_burst_gen_if.sv | 34 +++
 rtl/axi_dma_r_burst_gen_len_calc.sv | 38 +++
 rtl/axi_dma_r_burst_gen.sv | 122 ++++++++++++
 4 files changed

// File: rtl/axi_dma_r_burst_gen_pkg.sv
// Shared types and constants for the AXI DMA read burst generator.
package axi_dma_r_burst_gen_pkg;

    localparam int unsigned DDR_ADDR_W     = 32;
    localparam int unsigned MIG_BUS_W      = 256;
    localparam int unsigned AXI_LEN_W      = 8;
    localparam int unsigned AXI_4K_BYTES   = 4096;
    localparam int unsigned BYTES_PER_BEAT = MIG_BUS_W / 8;
    localparam int unsigned BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);

    typedef enum logic [1:0] {
        BG_IDLE = 2'd0,
        BG_CALC = 2'd1,
        BG_RUN  = 2'd2
    } bg_state_e;

    // Clear the sub-beat byte offset so every burst starts on a bus beat.
    function automatic logic [DDR_ADDR_W-1:0] align_addr(input logic [DDR_ADDR_W-1:0] a);
        return a & ~DDR_ADDR_W'(BYTES_PER_BEAT - 1);
    endfunction

endpackage

// File: rtl/axi_dma_r_burst_gen_if.sv
// Descriptor, status, engine request and read-data stream signals of the burst generator.
interface axi_dma_r_burst_gen_if #(
    parameter int unsigned BEATS_W = 20
) ();
    import axi_dma_r_burst_gen_pkg::*;

    logic                  start_valid;
    logic                  start_ready;
    logic [DDR_ADDR_W-1:0] start_addr;
    logic [BEATS_W-1:0]    start_beats;
    logic                  busy;
    logic                  done;
    logic                  dma_valid;
    logic [DDR_ADDR_W-1:0] dma_addr;
    logic [AXI_LEN_W-1:0]  dma_len;
    logic                  dma_ready;
    logic [MIG_BUS_W-1:0]  dma_rdata;
    logic                  out_valid;
    logic [MIG_BUS_W-1:0]  out_data;
    logic                  out_last;

    modport master (
        input  start_valid, start_addr, start_beats, dma_ready, dma_rdata,
        output start_ready, busy, done, dma_valid, dma_addr, dma_len,
               out_valid, out_data, out_last
    );

    modport slave (
        output start_valid, start_addr, start_beats, dma_ready, dma_rdata,
        input  start_ready, busy, done, dma_valid, dma_addr, dma_len,
               out_valid, out_data, out_last
    );

endinterface

// File: rtl/axi_dma_r_burst_gen_len_calc.sv
// Combinational burst size: min(remaining, MAX_BEATS[, beats to next 4 KB line]).
// The 4 KB term exists only when AXI_DMA_4K_SPLIT_EN is defined.
module axi_dma_r_burst_gen_len_calc
    import axi_dma_r_burst_gen_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned BEATS_W   = 20
) (
    input  logic [11:0]        cur_addr_lo_i,
    input  logic [BEATS_W-1:0] remaining_i,
    output logic [BEATS_W:0]   n_o
);
    localparam int unsigned NW = BEATS_W + 1;

    logic [NW-1:0] rem_w;

`ifdef AXI_DMA_4K_SPLIT_EN
    logic [NW-1:0] beats_to_4k;

    always_comb begin
        rem_w       = NW'(remaining_i);
        beats_to_4k = (NW'(AXI_4K_BYTES) - NW'(cur_addr_lo_i)) >> BEAT_SHIFT;
        n_o         = (rem_w < NW'(MAX_BEATS)) ? rem_w : NW'(MAX_BEATS);
        if (beats_to_4k < n_o) begin
            n_o = beats_to_4k;
        end
    end
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^cur_addr_lo_i;

    always_comb begin
        rem_w = NW'(remaining_i);
        n_o   = (rem_w < NW'(MAX_BEATS)) ? rem_w : NW'(MAX_BEATS);
    end
`endif

endmodule

// File: rtl/axi_dma_r_burst_gen.sv
// Splits one read descriptor into AXI INCR bursts and forwards engine beats with a transfer-level last.
// Define AXI_DMA_4K_SPLIT_EN to keep every burst inside one 4 KB line.
module axi_dma_r_burst_gen
    import axi_dma_r_burst_gen_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned BEATS_W   = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_dma_r_burst_gen_if.master bus
);
    localparam int unsigned NW  = BEATS_W + 1;
    localparam int unsigned LW1 = AXI_LEN_W + 1;

    bg_state_e             state_q, state_d;
    logic [DDR_ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [BEATS_W-1:0]    remaining_q, remaining_d;
    logic [AXI_LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [AXI_LEN_W-1:0]  dma_len_q, dma_len_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic [NW-1:0]         calc_n;
    logic [LW1-1:0]        burst_n;
    logic                  beat_c;
    logic                  burst_end_c;
    logic                  xfer_end_c;

    axi_dma_r_burst_gen_len_calc #(
        .MAX_BEATS (MAX_BEATS),
        .BEATS_W   (BEATS_W)
    ) u_len_calc (
        .cur_addr_lo_i (cur_addr_q[11:0]),
        .remaining_i   (remaining_q),
        .n_o           (calc_n)
    );

    // Beat bookkeeping for the burst currently presented to the engine.
    assign burst_n     = LW1'(dma_len_q) + LW1'(1);
    assign beat_c      = (state_q == BG_RUN) && bus.dma_ready;
    assign burst_end_c = beat_c && (beat_cnt_q == dma_len_q);
    assign xfer_end_c  = burst_end_c && (remaining_q == BEATS_W'(burst_n));

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        dma_len_d   = dma_len_q;
        done_d      = 1'b0;

        unique case (state_q)
            BG_IDLE: begin
                if (bus.start_valid) begin
                    cur_addr_d  = align_addr(bus.start_addr);
                    remaining_d = bus.start_beats;
                    beat_cnt_d  = '0;
                    if (bus.start_beats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = BG_CALC;
                    end
                end
            end
            BG_CALC: begin
                dma_len_d = AXI_LEN_W'(calc_n - NW'(1));
                state_d   = BG_RUN;
            end
            BG_RUN: begin
                if (burst_end_c) begin
                    cur_addr_d  = cur_addr_q + (DDR_ADDR_W'(burst_n) << BEAT_SHIFT);
                    remaining_d = remaining_q - BEATS_W'(burst_n);
                    beat_cnt_d  = '0;
                    if (xfer_end_c) begin
                        state_d = BG_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BG_CALC;
                    end
                end else if (beat_c) begin
                    beat_cnt_d = beat_cnt_q + AXI_LEN_W'(1);
                end
            end
            default: state_d = BG_IDLE;
        endcase

        busy_d = (state_d != BG_IDLE) || done_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= BG_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            dma_len_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            dma_len_q   <= dma_len_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // Request fields come straight from state registers, so they hold for the whole burst.
    assign bus.start_ready = (state_q == BG_IDLE);
    assign bus.dma_valid   = (state_q == BG_RUN);
    assign bus.dma_addr    = cur_addr_q;
    assign bus.dma_len     = dma_len_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.out_valid   = beat_c;
    assign bus.out_data    = bus.dma_rdata;
    assign bus.out_last    = xfer_end_c;

endmodule
